regfile_wb_sched: RTL and testbench
===================================

# regfile_wb_sched

Write-back scheduler and hazard scoreboard for the 64 x 32-bit register file. It arbitrates up to NREQ write-back requesters (ALU, load unit, multiplier) onto the register file's single write port using round-robin arbitration with a valid/ready handshake. It drives the registered we/wa/wd signals into the register file's WE1/WA/WD inputs. It also keeps a per-register busy scoreboard so the issue stage stalls on RAW and WAW hazards until the pending write has landed.

## Interface
- NREQ, 3, number of write-back requesters (2..4)
- AW, 6, register address width (64 registers)
- DW, 32, data width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*AW  destination of requester i, slice [i*AW +: AW]
- req_data  in  NREQ*DW  write data of requester i, slice [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant, combinational
- we  out  1  register file write enable, registered
- wa  out  AW  register file write address, registered
- wd  out  DW  register file write data, registered
- iss_valid  in  1  issue stage presents an instruction
- iss_rd  in  AW  destination of the issuing instruction
- iss_rs  in  AW  source A of the issuing instruction
- iss_rt  in  AW  source B of the issuing instruction
- iss_stall  out  1  hazard; the issue must not proceed, combinational

## Operation
- Handshake: a transfer on requester i occurs when req_valid[i] and req_ready[i] are both high at a rising edge. The requester holds valid, addr and data stable until it is granted. The requester may not drop valid before the grant.
- Arbitration: at most one req_ready bit is high per cycle, and only to a valid requester. Priority search starts at pointer ptr and wraps. After a grant to i, ptr becomes (i+1) mod NREQ. With no grant, ptr is unchanged.
- Write path: on a transfer, the next cycle has we=1, wa=req_addr[i], wd=req_data[i]. With no transfer, the next cycle has we=0, and wa/wd hold their previous values.
- Register 0: a transfer to address 0 completes normally (ready is given), but the next-cycle we is 0.
- Scoreboard: busy[63:0], where busy[0] is always 0.
  - iss_stall = iss_valid & (busy[iss_rs] | busy[iss_rt] | busy[iss_rd]).
  - Set: at an edge with iss_valid & !iss_stall & iss_rd!=0, busy[iss_rd] becomes 1.
  - Clear: at an edge with we=1, busy[wa] becomes 0. The clear happens at the same edge the register file captures the data.
  - Simultaneous set and clear of the same address: set wins, because a new producer is pending.
- The scoreboard does not check that write-back addresses match issued destinations; the pipeline guarantees one write-back per issued destination.

## Timing
- Reset values: we=0, wa=0, wd=0, ptr=0, busy all 0. req_ready and iss_stall then follow their combinational equations; with no request, req_ready=0.
- Handshake to we: 1 cycle. Handshake to data visible on a register file read: 2 edges.
- The issue of a consumer unstalls in the cycle after we=1 for its register, when the register file already holds the new value. No bypass is provided.
- Sustained throughput is 1 write per cycle. With all NREQ requesters valid continuously, each is granted once every NREQ cycles.
- Reset mid-operation:
  - Pending requests are not granted while rst is high.
  - Any we in flight is dropped (we=0 next cycle).
  - The scoreboard is cleared and ptr returns to 0.

## Structure
- A shared package regfile_pkg holds: REG_AW=6, REG_DW=32, NUM_REGS=64, ZERO_REG=0, and the requester index constants WB_ALU=0, WB_LOAD=1, WB_MUL=2.
- Sub-module rr_arbiter (parameter N, inputs req/advance, output one-hot gnt, with its own pointer) is reusable for memory-port sharing. The scoreboard and the write register stay inline.

## Test plan
- Reset, then req0 (addr 5, data 0xDEADBEEF) alone -> req_ready=001 the same cycle; next cycle we=1, wa=5, wd=0xDEADBEEF; the cycle after, we=0.
- All three requesters valid for 6 cycles, all others idle -> grants 0,1,2,0,1,2, with exactly one we per cycle carrying the matching data.
- Issue rd=7 (no stall), then issue rs=7 -> iss_stall=1 until the cycle after we=1/wa=7; then iss_stall=0.
- Write-back to address 0 with data 0x1234 -> ready granted, we stays 0, busy unchanged. Issue with rd=0 never sets busy or stalls.
- Same edge: we=1/wa=9 clears and a new issue sets rd=9 -> busy[9]=1 afterwards, so a later rs=9 stalls.
- Assert rst while req1 is pending and busy[3]=1 -> next cycle we=0, ptr=0, and busy[3]=0. After release, req1 is granted.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and write-back requester indices.
package regfile_pkg;
  localparam int REG_AW   = 6;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 64;
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_MUL  = 2'd2
  } wb_src_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer moves past the
// winner only when the grant is consumed (advance).
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        if (advance) ptr_d = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the register file's single write port plus a
// per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              we,
  output logic [AW-1:0]     wa,
  output logic [DW-1:0]     wd,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [AW-1:0]     iss_rs,
  input  logic [AW-1:0]     iss_rt,
  output logic              iss_stall
);
  localparam int NR = 2 ** AW;

  logic [NREQ-1:0] req_eff;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            we_q, we_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic [NR-1:0]   busy_q, busy_d;

  // Requests are masked during reset so nothing is granted while rst is high.
  assign req_eff = req_valid & {NREQ{~rst}};
  assign xfer    = |req_ready;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_eff),
    .advance (xfer),
    .gnt     (req_ready)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Writes to the zero register are accepted but never reach the file.
  always_comb begin
    we_d = xfer && (sel_addr != AW'(ZERO_REG));
    wa_d = xfer ? sel_addr : wa_q;
    wd_d = xfer ? sel_data : wd_q;
  end

  assign iss_stall = iss_valid & (busy_q[iss_rs] | busy_q[iss_rt] | busy_q[iss_rd]);

  // Set is applied after clear so a newly issued producer keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[wa_q] = 1'b0;
    if (iss_valid && !iss_stall && (iss_rd != AW'(ZERO_REG))) busy_d[iss_rd] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
    end
  end

  assign we = we_q;
  assign wa = wa_q;
  assign wd = wd_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Randomized + directed bench for regfile_wb_sched against a behavioural model.
module tb_regfile_wb_sched;
  import regfile_pkg::*;

  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*6-1:0] req_addr = '0;
  logic [NREQ*32-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              we;
  logic [5:0]        wa;
  logic [31:0]       wd;
  logic              iss_valid = 1'b0;
  logic [5:0]        iss_rd = '0, iss_rs = '0, iss_rt = '0;
  logic              iss_stall;

  regfile_wb_sched #(.NREQ(NREQ), .AW(6), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .we(we), .wa(wa), .wd(wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_stall(iss_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // requester-side state (what each requester is holding)
  bit          pend [NREQ];
  logic [5:0]  paddr[NREQ];
  logic [31:0] pdata[NREQ];

  // reference model
  int          m_ptr = 0;
  bit [63:0]   m_busy = '0;
  bit          m_we = 1'b0;
  logic [5:0]  m_wa = '0;
  logic [31:0] m_wd = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One clock: drive at negedge, check outputs, then advance the model to the next edge.
  task automatic cycle(input bit r, input bit iv, input logic [5:0] rd,
                       input logic [5:0] rs, input logic [5:0] rt);
    int         g;
    logic [2:0] exp_rdy;
    bit         exp_stall;
    @(negedge clk);
    rst = r; iss_valid = iv; iss_rd = rd; iss_rs = rs; iss_rt = rt;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = pend[i];
      req_addr[i*6 +: 6]   = paddr[i];
      req_data[i*32 +: 32] = pdata[i];
    end
    #1;
    g = -1;
    if (!r) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (g < 0 && pend[i]) g = i;
      end
    end
    exp_rdy   = (g < 0) ? 3'b000 : 3'(1 << g);
    exp_stall = iv && (m_busy[rs] || m_busy[rt] || m_busy[rd]);
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    check_eq("iss_stall", 64'(iss_stall), 64'(exp_stall));
    check_eq("we", 64'(we), 64'(m_we));
    check_eq("wa", 64'(wa), 64'(m_wa));
    check_eq("wd", 64'(wd), 64'(m_wd));
    $display("cyc rst=%0b valid=%b ready=%b stall=%0b we=%0b wa=%0d wd=%08h",
             r, req_valid, req_ready, iss_stall, we, wa, wd);
    if (r) begin
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_ptr = 0; m_busy = '0;
    end else begin
      if (m_we) m_busy[m_wa] = 1'b0;
      if (iv && !exp_stall && rd != 6'd0) m_busy[rd] = 1'b1;
      if (g >= 0) begin
        m_we  = (paddr[g] != 6'd0);
        m_wa  = paddr[g];
        m_wd  = pdata[g];
        m_ptr = (g + 1) % NREQ;
        pend[g] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
    end
  endtask

  task automatic post(input int i, input logic [5:0] a, input logic [31:0] d);
    pend[i] = 1'b1; paddr[i] = a; pdata[i] = d;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; paddr[i] = '0; pdata[i] = '0; end

    // reset, then single ALU write-back
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    post(WB_ALU, 6'd5, 32'hDEADBEEF);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // all requesters valid continuously after a fresh reset
    cycle(1, 0, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i]) post(i, 6'(10 + i), 32'h1000_0000 + 32'(c * 16 + i));
      cycle(0, 0, 0, 0, 0);
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // RAW on r7: stall until the cycle after the write lands
    cycle(0, 1, 6'd7, 6'd1, 6'd2);
    cycle(0, 1, 6'd8, 6'd7, 6'd2);
    cycle(0, 1, 6'd8, 6'd7, 6'd2);
    post(WB_MUL, 6'd7, 32'hCAFE0007);
    for (int c = 0; c < 4; c++) cycle(0, 1, 6'd8, 6'd7, 6'd2);

    // zero register: accepted, never written, never busy
    post(WB_LOAD, 6'd0, 32'h0000_1234);
    cycle(0, 1, 6'd0, 6'd0, 6'd0);
    cycle(0, 1, 6'd0, 6'd0, 6'd0);
    cycle(0, 1, 6'd0, 6'd0, 6'd0);

    // same-edge clear and set of r9: set wins
    post(WB_ALU, 6'd9, 32'h9999_0009);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 6'd9, 6'd1, 6'd2);
    cycle(0, 1, 6'd4, 6'd9, 6'd2);
    cycle(0, 1, 6'd4, 6'd9, 6'd2);

    // reset mid-operation with a write in flight and req1 pending
    cycle(0, 1, 6'd3, 6'd1, 6'd2);
    post(WB_ALU, 6'd10, 32'hAAAA_000A);
    cycle(0, 0, 0, 0, 0);
    post(WB_LOAD, 6'd3, 32'h3333_0003);
    cycle(1, 1, 6'd5, 6'd3, 6'd5);
    cycle(0, 1, 6'd5, 6'd3, 6'd5);
    cycle(0, 0, 0, 0, 0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      bit r;
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1)
          post(i, 6'($urandom_range(0, 15)), $urandom);
      r = ($urandom_range(0, 59) == 0);
      cycle(r, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)),
            6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
